// File: rtl/dut_host_master.sv
// Host master for the OR-combiner: writes operands a/b, polls status, reads the OR result, returns it on rsp.
// Latency: rsp_valid on the 7th edge counting the accept edge when unstalled; stalls on status/rdy bits and holds rsp until rsp_ready. Optional POLL_Y timeout: DUT_HOST_MASTER_TIMEOUT_EN.
module dut_host_master #(
    parameter int POLL_LIMIT = 1023
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [2:0] write_address,
    output logic [7:0] write_data,
    output logic       write_en,
    input  logic       write_rdy,
    output logic [2:0] read_address,
    output logic       read_en,
    input  logic [7:0] read_data,
    input  logic       read_rdy,
    output logic [7:0] txn_count
);

    typedef enum logic [2:0] {
        IDLE,
        POLL_A,
        WR_A,
        POLL_B,
        WR_B,
        POLL_Y,
        RD_Y,
        RSP
    } state_t;

    localparam logic [2:0] ADDR_STAT_A = 3'd0;
    localparam logic [2:0] ADDR_STAT_B = 3'd1;
    localparam logic [2:0] ADDR_STAT_Y = 3'd2;
    localparam logic [2:0] ADDR_Y      = 3'd3;
    localparam logic [2:0] ADDR_A      = 3'd4;
    localparam logic [2:0] ADDR_B      = 3'd5;

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic [7:0] txn_count_q, txn_count_d;

    logic       cmd_ready_q, cmd_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [2:0] write_address_q, write_address_d;
    logic [7:0] write_data_q, write_data_d;
    logic       write_en_q, write_en_d;
    logic [2:0] read_address_q, read_address_d;
    logic       read_en_q, read_en_d;

`ifdef DUT_HOST_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(POLL_LIMIT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(POLL_LIMIT - 1);

    logic             rsp_err_q, rsp_err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    logic unused_poll_limit;
    assign unused_poll_limit = |POLL_LIMIT;
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_data_d  = rsp_data_q;
        txn_count_d = txn_count_q;
`ifdef DUT_HOST_MASTER_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
        tmo_d       = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    state_d = POLL_A;
                end
            end
            POLL_A: begin
                if (read_rdy && read_data[0]) begin
                    state_d = WR_A;
                end
            end
            WR_A: begin
                if (write_rdy) begin
                    state_d = POLL_B;
                end
            end
            POLL_B: begin
                if (read_rdy && read_data[0]) begin
                    state_d = WR_B;
                end
            end
            WR_B: begin
                if (write_rdy) begin
                    state_d = POLL_Y;
`ifdef DUT_HOST_MASTER_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            POLL_Y: begin
                if (read_rdy && read_data[0]) begin
                    state_d = RD_Y;
                end
`ifdef DUT_HOST_MASTER_TIMEOUT_EN
                // Result readiness wins over an expiring count in the same cycle.
                else if (tmo_q == TMO_LAST) begin
                    state_d    = RSP;
                    rsp_data_d = 8'h00;
                    rsp_err_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            RD_Y: begin
                if (read_rdy) begin
                    rsp_data_d = read_data;
                    state_d    = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    txn_count_d = txn_count_q + 8'd1;
                    rsp_data_d  = 8'h00;
`ifdef DUT_HOST_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state_q.
    always_comb begin
        cmd_ready_d     = (state_d == IDLE);
        rsp_valid_d     = (state_d == RSP);
        write_en_d      = 1'b0;
        write_address_d = 3'd0;
        write_data_d    = 8'h00;
        read_en_d       = 1'b0;
        read_address_d  = 3'd0;
        case (state_d)
            POLL_A: begin
                read_en_d      = 1'b1;
                read_address_d = ADDR_STAT_A;
            end
            WR_A: begin
                write_en_d      = 1'b1;
                write_address_d = ADDR_A;
                write_data_d    = a_d;
            end
            POLL_B: begin
                read_en_d      = 1'b1;
                read_address_d = ADDR_STAT_B;
            end
            WR_B: begin
                write_en_d      = 1'b1;
                write_address_d = ADDR_B;
                write_data_d    = b_d;
            end
            POLL_Y: begin
                read_en_d      = 1'b1;
                read_address_d = ADDR_STAT_Y;
            end
            RD_Y: begin
                read_en_d      = 1'b1;
                read_address_d = ADDR_Y;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= IDLE;
            a_q             <= 8'h00;
            b_q             <= 8'h00;
            rsp_data_q      <= 8'h00;
            txn_count_q     <= 8'h00;
            cmd_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            write_address_q <= 3'd0;
            write_data_q    <= 8'h00;
            write_en_q      <= 1'b0;
            read_address_q  <= 3'd0;
            read_en_q       <= 1'b0;
`ifdef DUT_HOST_MASTER_TIMEOUT_EN
            rsp_err_q       <= 1'b0;
            tmo_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            a_q             <= a_d;
            b_q             <= b_d;
            rsp_data_q      <= rsp_data_d;
            txn_count_q     <= txn_count_d;
            cmd_ready_q     <= cmd_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            write_en_q      <= write_en_d;
            read_address_q  <= read_address_d;
            read_en_q       <= read_en_d;
`ifdef DUT_HOST_MASTER_TIMEOUT_EN
            rsp_err_q       <= rsp_err_d;
            tmo_q           <= tmo_d;
`endif
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign write_en      = write_en_q;
    assign read_address  = read_address_q;
    assign read_en       = read_en_q;
    assign txn_count     = txn_count_q;
`ifdef DUT_HOST_MASTER_TIMEOUT_EN
    assign rsp_err       = rsp_err_q;
`else
    assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_dut_host_master.sv
// Bench for dut_host_master with a behavioural OR-combiner slave; DUT_HOST_MASTER_TIMEOUT_EN enables the timeout sequence.
module tb_dut_host_master;

    logic       CLK;
    logic       RST;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [2:0] write_address;
    logic [7:0] write_data;
    logic       write_en;
    logic       write_rdy;
    logic [2:0] read_address;
    logic       read_en;
    logic [7:0] read_data;
    logic       read_rdy = 1'b1;
    logic [7:0] txn_count;

    dut_host_master #(.POLL_LIMIT(16)) u_dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .write_address(write_address), .write_data(write_data), .write_en(write_en), .write_rdy(write_rdy),
        .read_address(read_address), .read_en(read_en), .read_data(read_data), .read_rdy(read_rdy),
        .txn_count(txn_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Slave knobs (written only by the main thread)
    int   st_a = 0, st_b = 0, st_y = 0, wst_a = 0, wst_b = 0;
    logic y_hold = 1'b0, rd_rand = 1'b0;

    // Slave / monitor state (written only by the posedge monitor)
    int   cyc = 0, pc_a = 0, pc_b = 0, pc_y = 0, wcnt = 0;
    int   n_a0 = 0, n_y2 = 0, n_rd3 = 0, n_wen4 = 0, n_wen5 = 0, first_wen = -1, last_a0 = -1;
    logic wdat_bad = 1'b0, y_vld = 1'b0, err_seen = 1'b0;
    logic [7:0] reg_a = 8'h00, reg_b = 8'h00;
    logic [10:0] wr_log[$];

    always @(negedge CLK) read_rdy = rd_rand ? ($urandom_range(3) != 0) : 1'b1;

    always_comb begin
        read_data = 8'h00;
        case (read_address)
            3'd0: read_data = {7'd0, pc_a >= st_a};
            3'd1: read_data = {7'd0, pc_b >= st_b};
            3'd2: read_data = {7'd0, y_vld && !y_hold && (pc_y >= st_y)};
            3'd3: read_data = reg_a | reg_b;
            default: read_data = 8'h00;
        endcase
    end

    always_comb begin
        write_rdy = 1'b1;
        if (write_en) write_rdy = (wcnt >= ((write_address == 3'd4) ? wst_a : wst_b));
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!RST && rsp_err === 1'b1) err_seen <= 1'b1;
        if (RST || (cmd_valid && cmd_ready)) begin
            pc_a <= 0; pc_b <= 0; pc_y <= 0; wcnt <= 0;
            n_a0 <= 0; n_y2 <= 0; n_rd3 <= 0; n_wen4 <= 0; n_wen5 <= 0;
            first_wen <= -1; last_a0 <= -1; wdat_bad <= 1'b0; y_vld <= 1'b0;
            wr_log.delete();
            if (RST) begin reg_a <= 8'h00; reg_b <= 8'h00; end
        end else begin
            if (read_en) begin
                case (read_address)
                    3'd0: begin n_a0 <= n_a0 + 1; last_a0 <= cyc; if (read_rdy) pc_a <= pc_a + 1; end
                    3'd1: if (read_rdy) pc_b <= pc_b + 1;
                    3'd2: begin n_y2 <= n_y2 + 1; if (read_rdy) pc_y <= pc_y + 1; end
                    3'd3: if (read_rdy) begin n_rd3 <= n_rd3 + 1; y_vld <= 1'b0; end
                    default: ;
                endcase
            end
            if (write_en) begin
                if (first_wen < 0) first_wen <= cyc;
                if (write_address == 3'd4) begin
                    n_wen4 <= n_wen4 + 1;
                    if (write_data !== cmd_a) wdat_bad <= 1'b1;
                end else if (write_address == 3'd5) begin
                    n_wen5 <= n_wen5 + 1;
                    if (write_data !== cmd_b) wdat_bad <= 1'b1;
                end else begin
                    wdat_bad <= 1'b1;
                end
                if (write_rdy) begin
                    wr_log.push_back({write_address, write_data});
                    wcnt <= 0;
                    if (write_address == 3'd4) reg_a <= write_data;
                    if (write_address == 3'd5) begin reg_b <= write_data; y_vld <= 1'b1; end
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    int         checks = 0, errors = 0;
    logic [7:0] exp_txn = 8'h00;
    logic       dead = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issue one command, wait for the response, hold rsp_ready low for rstall cycles, then complete it.
    task automatic do_cmd(input string nm, input logic [7:0] a, input logic [7:0] b, input int rstall,
                          input logic [7:0] edat, input logic eerr, output int lat);
        int   n;
        logic held;
        cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin @(posedge CLK); #1; n++; end
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 300) begin @(posedge CLK); #1; lat++; end
        chk({nm, " rsp_valid_seen"}, rsp_valid, 1);
        if (!rsp_valid) begin dead = 1'b1; return; end
        chk({nm, " rsp_data"}, rsp_data, edat);
        chk({nm, " rsp_err"}, rsp_err, eerr);
        held = 1'b1;
        for (int i = 0; i < rstall; i++) begin
            @(posedge CLK); #1;
            if (!rsp_valid || rsp_data !== edat || cmd_ready !== 1'b0 || txn_count !== exp_txn) held = 1'b0;
        end
        chk({nm, " rsp_held"}, held, 1);
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
        exp_txn = exp_txn + 8'd1;
        chk({nm, " rsp_drop"}, rsp_valid, 0);
        chk({nm, " cmd_ready_back"}, cmd_ready, 1);
        chk({nm, " txn_count"}, txn_count, exp_txn);
    endtask

    // Expected bus traffic for an ordinary command: write a at 4, then b at 5, one result dequeue.
    task automatic chk_bus(input string nm, input logic [7:0] a, input logic [7:0] b);
        chk({nm, " n_writes"}, wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk({nm, " write0"}, wr_log[0], {3'd4, a});
            chk({nm, " write1"}, wr_log[1], {3'd5, b});
        end
        chk({nm, " wdata_stable"}, wdat_bad, 0);
        chk({nm, " y_dequeues"}, n_rd3, 1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         rstall;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int   lat, n, hold_cyc;
        logic ok;
        logic [7:0] ra, rb;

        tbl[0] = '{8'h0F, 8'hF0, 0, 8'hFF};
        tbl[1] = '{8'h00, 8'h00, 0, 8'h00};
        tbl[2] = '{8'hA5, 8'h5A, 1, 8'hFF};
        tbl[3] = '{8'h81, 8'h18, 2, 8'h99};
        tbl[4] = '{8'h30, 8'h0C, 10, 8'h3C};
        tbl[5] = '{8'h40, 8'h01, 0, 8'h41};

        RST = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_data", rsp_data, 0);
        chk("reset rsp_err", rsp_err, 0);
        chk("reset write_en", write_en, 0);
        chk("reset read_en", read_en, 0);
        chk("reset addrs", {write_address, read_address, write_data}, 0);
        chk("reset txn_count", txn_count, 0);

        // Unstalled vectors: rsp_valid rises on the 7th edge counting the accept edge itself.
        for (int i = 0; i < 6; i++) begin
            do_cmd($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].rstall, tbl[i].exp, 1'b0, lat);
            chk($sformatf("vec%0d latency_edges", i), lat + 1, 7);
            chk_bus($sformatf("vec%0d", i), tbl[i].a, tbl[i].b);
        end

        st_a = 5;
        do_cmd("poll_a", 8'h12, 8'h34, 0, 8'h36, 1'b0, lat);
        chk("poll_a cycles", n_a0, 6);
        chk("poll_a write_after_poll", first_wen > last_a0, 1);
        chk("poll_a addr4_wen_cycles", n_wen4, 1);
        chk_bus("poll_a", 8'h12, 8'h34);
        st_a = 0;

        wst_b = 3;
        do_cmd("wr_b_stall", 8'h0A, 8'hC5, 0, 8'hCF, 1'b0, lat);
        chk("wr_b_stall addr5_wen_cycles", n_wen5, 4);
        chk_bus("wr_b_stall", 8'h0A, 8'hC5);
        wst_b = 0;

        rd_rand = 1'b1;
        for (int i = 0; i < 260 && !dead; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            st_a = $urandom_range(3); st_b = $urandom_range(3); st_y = $urandom_range(3);
            wst_a = $urandom_range(2); wst_b = $urandom_range(2);
            do_cmd($sformatf("rnd%0d", i), ra, rb, $urandom_range(3), ra | rb, 1'b0, lat);
            chk_bus($sformatf("rnd%0d", i), ra, rb);
        end
        rd_rand = 1'b0;
        st_a = 0; st_b = 0; st_y = 0; wst_a = 0; wst_b = 0;
        @(posedge CLK); #1;

`ifdef DUT_HOST_MASTER_TIMEOUT_EN
        y_hold = 1'b1;
        do_cmd("timeout", 8'h55, 8'hAA, 2, 8'h00, 1'b1, lat);
        chk("timeout poll_y_cycles", n_y2, 16);
        chk("timeout y_reads", n_rd3, 0);
        y_hold = 1'b0;
        hold_cyc = 5;
`else
        hold_cyc = 40;
`endif

        // Reset while parked in POLL_Y.
        y_hold = 1'b1;
        cmd_a = 8'h11; cmd_b = 8'h22; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin @(posedge CLK); #1; n++; end
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!(read_en && read_address == 3'd2) && n < 50) begin @(posedge CLK); #1; n++; end
        chk("rst reach_poll_y", read_en && read_address == 3'd2, 1);
        ok = 1'b1;
        repeat (hold_cyc) begin
            @(posedge CLK); #1;
            if (rsp_valid !== 1'b0 || read_en !== 1'b1 || read_address !== 3'd2) ok = 1'b0;
        end
        chk("rst poll_y_waits", ok, 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_txn = 8'h00;
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst txn_count", txn_count, 0);
        chk("rst rsp_data", rsp_data, 0);
        ok = 1'b1;
        repeat (3) begin
            if (read_en !== 1'b0 || write_en !== 1'b0 || cmd_ready !== 1'b1) ok = 1'b0;
            @(posedge CLK); #1;
        end
        chk("rst bus_quiet", ok, 1);
        y_hold = 1'b0;
        do_cmd("rst_fresh", 8'h01, 8'h02, 0, 8'h03, 1'b0, lat);
        chk_bus("rst_fresh", 8'h01, 8'h02);

`ifndef DUT_HOST_MASTER_TIMEOUT_EN
        chk("rsp_err_never_set", err_seen, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
